// File: rtl/mem_pkg.sv
// Shared constants, helper function and read-pipeline tag type for the memory model.
package mem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Number of byte lanes in a data word.
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // Control half of a read-pipeline stage. The data half depends on DATA_W,
    // so mem_rd_pipe wraps this together with the data into its stage struct.
    typedef struct packed {
        logic valid;
        logic err;
    } rd_ctl_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// RD_LAT-stage read return pipeline. Valid and err advance every cycle. Data
// only advances behind a valid entry, so the last stage keeps the most recent
// returned word while the output is idle.
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_err,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data
);

    typedef struct packed {
        rd_ctl_t           ctl;
        logic [DATA_W-1:0] data;
    } rd_stage_t;

    rd_stage_t stage [RD_LAT];

    // Shift register of read stages; reset drops every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0].ctl.valid <= req_valid;
            stage[0].ctl.err   <= req_valid & req_err;
            if (req_valid) begin
                stage[0].data <= req_data;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i].ctl <= stage[i-1].ctl;
                if (stage[i-1].ctl.valid) begin
                    stage[i].data <= stage[i-1].data;
                end
            end
        end
    end

    assign rsp_valid = stage[RD_LAT-1].ctl.valid;
    assign rsp_err   = stage[RD_LAT-1].ctl.err;
    assign rsp_data  = stage[RD_LAT-1].data;

endmodule

// File: rtl/mem_model_pipe.sv
// Single-port memory model with byte strobes, pipelined reads (write-first on
// a same-cycle access) and out-of-range error reporting.
module mem_model_pipe
    import mem_pkg::*;
#(
    parameter int                       ADDR_W    = 8,
    parameter int                       DATA_W    = 32,
    parameter int                       DEPTH     = 2**ADDR_W,
    parameter int                       RD_LAT    = 2,
    parameter logic [DATA_W-1:0]        RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [strb_w(DATA_W)-1:0]   wstrb,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rvalid,
    output logic                        err
);

    localparam int SW = strb_w(DATA_W);

    generate
        if ((DATA_W % 8) != 0 || DEPTH < 1 || DEPTH > 2**ADDR_W ||
            RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_param
            $error("mem_model_pipe: illegal DATA_W/DEPTH/RD_LAT parameters");
        end
    endgenerate

    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_word;
    logic              wr_err;
    logic              pipe_err;

    assign in_range = {1'b0, addr} < DEPTH_X;
    assign cur_word = in_range ? mem[addr] : '0;

    // Strobed lanes take wdata, the rest keep the stored word; a read in the
    // same cycle sees this merged value.
    always_comb begin
        merged = cur_word;
        for (int i = 0; i < SW; i++) begin
            if (wr_en && wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    assign rd_word = in_range ? merged : '0;

    // Storage array: async reinitialise, byte-merged write when in range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (wr_en && in_range) begin
            mem[addr] <= merged;
        end
    end

    // One-cycle pulse after an out-of-range write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en & ~in_range;
        end
    end

    mem_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (reset),
        .req_valid (rd_en),
        .req_err   (~in_range),
        .req_data  (rd_word),
        .rsp_valid (rvalid),
        .rsp_err   (pipe_err),
        .rsp_data  (rdata)
    );

    assign err = wr_err | pipe_err;

endmodule

// File: tb/tb_mem_model_pipe.sv
// Directed bench for mem_model_pipe. Three instances share the stimulus:
//   a: DEPTH 256, RD_LAT 2, RESET_VAL DEADBEEF
//   b: DEPTH 200, RD_LAT 2, RESET_VAL 0 (out-of-range and write-first cases)
//   c: DEPTH 256, RD_LAT 3, RESET_VAL DEADBEEF (reset mid-read)
module tb_mem_model_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic        err_a, err_b, err_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_model_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .RD_LAT(2),
                     .RESET_VAL(32'hDEAD_BEEF)) dut_a (
        .clk(clk), .reset(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wstrb(wstrb), .wdata(wdata), .rdata(rdata_a), .rvalid(rvalid_a), .err(err_a));

    mem_model_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .RD_LAT(2),
                     .RESET_VAL(32'h0)) dut_b (
        .clk(clk), .reset(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wstrb(wstrb), .wdata(wdata), .rdata(rdata_b), .rvalid(rvalid_b), .err(err_b));

    mem_model_pipe #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .RD_LAT(3),
                     .RESET_VAL(32'hDEAD_BEEF)) dut_c (
        .clk(clk), .reset(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wstrb(wstrb), .wdata(wdata), .rdata(rdata_c), .rvalid(rvalid_c), .err(err_c));

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; wstrb = 4'h0; wdata = 32'h0; addr = 8'h0;
    endtask

    task automatic drive_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; rd_en = 1'b0; addr = a; wdata = d; wstrb = s;
    endtask

    task automatic drive_rd(input logic [7:0] a);
        wr_en = 1'b0; rd_en = 1'b1; addr = a; wstrb = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        total_cnt++;
        if ({rvalid_a, err_a, rdata_a} !== 34'h0)
            $display("FAIL reset_out_a: got v=%b e=%b d=%h, want 0/0/0", rvalid_a, err_a, rdata_a);
        else pass_cnt++;
        total_cnt++;
        if ({rvalid_c, err_c, rdata_c} !== 34'h0)
            $display("FAIL reset_out_c: got v=%b e=%b d=%h, want 0/0/0", rvalid_c, err_c, rdata_c);
        else pass_cnt++;
        rst = 1'b0;
        step();
        drive_rd(8'h00);
        step();
        total_cnt++;
        if (rvalid_a !== 1'b0)
            $display("FAIL reset_lat_early: rvalid=%b, want 0", rvalid_a);
        else pass_cnt++;
        drive_rd(8'hFF);
        step();
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEAD_BEEF || err_a !== 1'b0)
            $display("FAIL reset_rd_00: got v=%b d=%h e=%b, want 1/deadbeef/0", rvalid_a, rdata_a, err_a);
        else pass_cnt++;
        idle();
        step();
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEAD_BEEF || err_a !== 1'b0)
            $display("FAIL reset_rd_ff: got v=%b d=%h e=%b, want 1/deadbeef/0", rvalid_a, rdata_a, err_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rvalid_a !== 1'b0)
            $display("FAIL reset_rd_end: rvalid=%b, want 0", rvalid_a);
        else pass_cnt++;
    endtask

    task automatic test_byte_strobes();
        drive_wr(8'h10, 32'h1122_3344, 4'b1111);
        step();
        drive_wr(8'h10, 32'hAABB_CCDD, 4'b0101);
        step();
        drive_rd(8'h10);
        step();
        idle();
        step();
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'h11BB_33DD)
            $display("FAIL strobe_a: got v=%b d=%h, want 1/11bb33dd", rvalid_a, rdata_a);
        else pass_cnt++;
        total_cnt++;
        if (rvalid_b !== 1'b1 || rdata_b !== 32'h11BB_33DD)
            $display("FAIL strobe_b: got v=%b d=%h, want 1/11bb33dd", rvalid_b, rdata_b);
        else pass_cnt++;
        step();
    endtask

    task automatic test_same_cycle();
        drive_wr(8'h20, 32'h0000_00A5, 4'b0001);
        rd_en = 1'b1;
        step();
        idle();
        step();
        total_cnt++;
        if (rvalid_b !== 1'b1 || rdata_b !== 32'h0000_00A5)
            $display("FAIL wfirst_b: got v=%b d=%h, want 1/000000a5", rvalid_b, rdata_b);
        else pass_cnt++;
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'hDEAD_BEA5)
            $display("FAIL wfirst_a: got v=%b d=%h, want 1/deadbea5", rvalid_a, rdata_a);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            drive_wr(8'(i), 32'(i), 4'hF);
            step();
        end
        drive_rd(8'h01);
        step();
        drive_rd(8'h02);
        step();
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'd1)
            $display("FAIL b2b_0: got v=%b d=%h, want 1/1", rvalid_a, rdata_a);
        else pass_cnt++;
        drive_rd(8'h03);
        step();
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'd2)
            $display("FAIL b2b_1: got v=%b d=%h, want 1/2", rvalid_a, rdata_a);
        else pass_cnt++;
        idle();
        step();
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'd3)
            $display("FAIL b2b_2: got v=%b d=%h, want 1/3", rvalid_a, rdata_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rvalid_a !== 1'b0 || rdata_a !== 32'd3)
            $display("FAIL b2b_hold: got v=%b d=%h, want 0/3", rvalid_a, rdata_a);
        else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        drive_wr(8'd250, 32'hFFFF_FFFF, 4'hF);
        step();
        total_cnt++;
        if (err_b !== 1'b1 || err_a !== 1'b0)
            $display("FAIL oor_wr_pulse: got err_b=%b err_a=%b, want 1/0", err_b, err_a);
        else pass_cnt++;
        idle();
        step();
        total_cnt++;
        if (err_b !== 1'b0)
            $display("FAIL oor_wr_end: err_b=%b, want 0", err_b);
        else pass_cnt++;
        drive_rd(8'd250);
        step();
        total_cnt++;
        if (err_b !== 1'b0 || rvalid_b !== 1'b0)
            $display("FAIL oor_rd_early: got v=%b e=%b, want 0/0", rvalid_b, err_b);
        else pass_cnt++;
        idle();
        step();
        total_cnt++;
        if (rvalid_b !== 1'b1 || rdata_b !== 32'h0 || err_b !== 1'b1)
            $display("FAIL oor_rd: got v=%b d=%h e=%b, want 1/0/1", rvalid_b, rdata_b, err_b);
        else pass_cnt++;
        total_cnt++;
        if (rvalid_a !== 1'b1 || rdata_a !== 32'hFFFF_FFFF || err_a !== 1'b0)
            $display("FAIL inrange_250_a: got v=%b d=%h e=%b, want 1/ffffffff/0", rvalid_a, rdata_a, err_a);
        else pass_cnt++;
        step();
        total_cnt++;
        if (err_b !== 1'b0 || rvalid_b !== 1'b0)
            $display("FAIL oor_rd_end: got v=%b e=%b, want 0/0", rvalid_b, err_b);
        else pass_cnt++;
        drive_rd(8'h20);
        step();
        idle();
        step();
        total_cnt++;
        if (rvalid_b !== 1'b1 || rdata_b !== 32'h0000_00A5 || err_b !== 1'b0)
            $display("FAIL oor_unchanged: got v=%b d=%h e=%b, want 1/000000a5/0", rvalid_b, rdata_b, err_b);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset_mid_read();
        int seen;
        seen = 0;
        drive_rd(8'h10);
        step();
        rst = 1'b1;
        idle();
        #1;
        total_cnt++;
        if ({rvalid_c, err_c, rdata_c} !== 34'h0)
            $display("FAIL midrst_out: got v=%b e=%b d=%h, want 0/0/0", rvalid_c, err_c, rdata_c);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b0;
            step();
            if (rvalid_c !== 1'b0) seen++;
        end
        total_cnt++;
        if (seen != 0)
            $display("FAIL midrst_no_rvalid: rvalid cycles=%0d, want 0", seen);
        else pass_cnt++;
        drive_rd(8'h10);
        step();
        idle();
        step();
        total_cnt++;
        if (rvalid_c !== 1'b0)
            $display("FAIL midrst_lat3_early: rvalid=%b, want 0", rvalid_c);
        else pass_cnt++;
        step();
        total_cnt++;
        if (rvalid_c !== 1'b1 || rdata_c !== 32'hDEAD_BEEF || err_c !== 1'b0)
            $display("FAIL midrst_reread: got v=%b d=%h e=%b, want 1/deadbeef/0", rvalid_c, rdata_c, err_c);
        else pass_cnt++;
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_byte_strobes();
        test_same_cycle();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
